// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: multi-digit BCD up/down counter with selectable modulus, validated load and cascade terminal count
module bcd_updown_counter #(
    parameter int DIGITS = 2,
    parameter int MODULUS = 60,
    parameter bit STEP_DOWN_WRAP = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] cnt,
    output logic                tc,
    output logic                load_err
);
    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX = to_bcd(MODULUS - 1);

    logic [DIGITS-1:0] cy;
    logic [DIGITS-1:0] bw;
    logic [DIGITS-1:0] dig_ok;
    logic [W-1:0]      inc;
    logic [W-1:0]      dec;
    logic [W-1:0]      nxt;
    logic              load_ok;

    assign cy[0] = 1'b1;
    assign bw[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic [3:0] d;
        assign d = cnt[4*i +: 4];
        assign inc[4*i +: 4] = !cy[i] ? d : (d == 4'd9 ? 4'd0 : d + 4'd1);
        assign dec[4*i +: 4] = !bw[i] ? d : (d == 4'd0 ? 4'd9 : d - 4'd1);
        assign dig_ok[i] = load_val[4*i +: 4] <= 4'd9;
        if (i < DIGITS - 1) begin : g_chain
            assign cy[i+1] = cy[i] && d == 4'd9;
            assign bw[i+1] = bw[i] && d == 4'd0;
        end
    end

    // with every digit valid, packed BCD orders like the decimal value, so a plain compare suffices
    assign load_ok = &dig_ok && load_val <= MAX;

    // next count value for an enabled step, including modulus wrap and down-mode floor
    always_comb begin
        nxt = up ? (cnt == MAX ? '0 : inc) : (cnt == '0 ? (STEP_DOWN_WRAP ? MAX : '0) : dec);
    end

    assign tc = en && (up ? cnt == MAX : cnt == '0);

    // count register with rst > load > en > hold priority
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            load_err <= 1'b0;
        end else if (load) begin
            load_err <= !load_ok;
            if (load_ok) cnt <= load_val;
        end else begin
            load_err <= 1'b0;
            if (en) cnt <= nxt;
        end
    end
endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised successor to the lab decimal counter: a multi-digit BCD counter with a selectable modulus.
- Supports enable, up/down direction, synchronous parallel load and a terminal-count carry output for cascading.
- Sits between the board clock divider and the 7-segment digit driver in the counter lab designs.
- Digits are packed little-endian, 4 bits per digit.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); count width is 4*DIGITS.
- MODULUS, 60, count range is 0..MODULUS-1; must satisfy 2 <= MODULUS <= 10**DIGITS.
- STEP_DOWN_WRAP, 1, in down mode: 1 means 0 wraps to MODULUS-1; 0 means hold at 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable; counts one step per clk when high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_val  input  4*DIGITS  BCD value to load.
- cnt  output  4*DIGITS  current count as packed BCD; digit 0 is in bits [3:0].
- tc  output  1  terminal count, combinational from state: (up && cnt==MODULUS-1 && en) or (!up && cnt==0 && en).
- load_err  output  1  registered; set for one cycle when load_val is rejected.

Behaviour:
- Reset: rst sampled high at a clk edge sets cnt=0 and load_err=0. rst has priority over load and en.
- Priority per edge: rst > load > en > hold.
- Load, valid value (every digit <=9 and value < MODULUS): cnt=load_val on the next edge, load_err=0.
- Load, invalid value: cnt unchanged, load_err=1 for exactly one cycle.
- load is accepted regardless of en.
- Up count (en=1, up=1): BCD increment with ripple carry between digits. A digit goes 9 -> 0 and carries into the next digit.
  - At MODULUS-1 the next value is 0 (wrap).
- Down count (en=1, up=0): BCD decrement with borrow. A digit goes 0 -> 9 and borrows from the next digit.
  - At 0: the next value is MODULUS-1 if STEP_DOWN_WRAP=1, otherwise cnt stays 0.
- Latency: cnt updates one cycle after the edge where en/load/rst is sampled. tc is valid in the same cycle as cnt.
- tc is qualified by en, so cascading works: a higher stage's en connects to the lower stage's tc.
- Direction change takes effect on the edge where it is sampled; no pipeline.
- cnt never holds a non-BCD digit and never holds a value >= MODULUS.
- Registered state is cnt (4*DIGITS bits) plus load_err. tc is combinational.
- Implementation: a generate loop over digits with a per-digit carry/borrow chain, plus a modulus compare in binary-coded-decimal form (the MODULUS-1 constant is converted to BCD at elaboration).

Test Plan:
1. DIGITS=2, MODULUS=60: rst=1 for 2 cycles, then en=1, up=1 for 62 cycles -> cnt runs 00..59, then 00, 01. tc=1 only while cnt=0x59.
2. Digit carry: load 0x09 then count up -> 0x10; load 0x39 then count up -> 0x40. No 0x0A or 0x3A ever appears.
3. Down mode, STEP_DOWN_WRAP=1: load 0x01, up=0, 3 enabled edges -> 0x00, 0x59, 0x58. tc=1 at 0x00. With STEP_DOWN_WRAP=0: cnt stays 0x00.
4. Load validation: load 0x5A -> load_err pulses 1 cycle, cnt unchanged. Load 0x60 with MODULUS=60 -> rejected. Load 0x42 -> cnt=0x42, load_err=0.
5. Simultaneous events: rst=1 with load=1 and en=1 -> cnt=0x00. load=1 with en=1 -> load value wins. en=0 -> cnt holds across 5 edges.
6. Cascade: two instances (DIGITS=1, MODULUS=10, then MODULUS=6), the upper stage's en driven by the lower stage's tc -> the combined count matches scenario 1. Mid-count reset (e.g. at 0x37) gives 0x00 on the next edge.
